// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH.
// One full-subtractor cell plus a borrow flop processes one bit per clock,
// LSB first. A start/busy/done handshake frames each operation.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    count;

  logic d_bit;
  logic br_next;
  logic accept;

  // Full-subtractor cell on the current LSBs, and the accept condition for start.
  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  // Control FSM, operand/result shifting and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= 1'b0;
      count  <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_next;
          count  <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= {d_bit, res_sr[WIDTH-1:1]};
            bout  <= br_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor.
// A 4-bit instance is compared every cycle against a cycle-level model of the
// handshake; an 8-bit instance is exercised with edge and random operand pairs.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  int assert_count = 0;
  int fail_count   = 0;

  // Model state: phase 0 = idle, 1..4 = busy cycles, 5 = done cycle.
  int         m_phase = 0;
  logic [3:0] m_a     = '0;
  logic [3:0] m_b     = '0;
  logic [3:0] m_diff  = '0;
  logic       m_bout  = 1'b0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Handshake model: accept in idle/done, W busy cycles, then one done cycle with the result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_a     = '0;
      m_b     = '0;
      m_diff  = '0;
      m_bout  = 1'b0;
    end else if ((m_phase == 0 || m_phase == 5) && start) begin
      m_a     = a;
      m_b     = b;
      m_phase = 1;
    end else if (m_phase >= 1 && m_phase < 4) begin
      m_phase = m_phase + 1;
    end else if (m_phase == 4) begin
      m_phase = 5;
      m_diff  = 4'((int'(m_a) - int'(m_b)) & 15);
      m_bout  = (m_a < m_b);
    end else if (m_phase == 5) begin
      m_phase = 0;
    end
  end

  // Compare the 4-bit DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
    checkOutput("done", 32'(done), 32'(m_phase == 5));
    checkOutput("diff", 32'(diff), 32'(m_diff));
    checkOutput("bout", 32'(bout), 32'(m_bout));
  end

  task automatic applyStimulus(input logic s, input logic [3:0] a_v, input logic [3:0] b_v);
    @(negedge clk);
    start = s;
    a     = a_v;
    b     = b_v;
  endtask

  // Counts falling edges until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic run_op(input logic [3:0] a_v, input logic [3:0] b_v,
                        input logic [3:0] exp_diff, input logic exp_bout, input string tag);
    int cyc;
    applyStimulus(1'b1, a_v, b_v);
    applyStimulus(1'b0, a_v, b_v);
    wait_done(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'd4);
    checkOutput({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    checkOutput({tag, "_bout"}, 32'(bout), 32'(exp_bout));
  endtask

  task automatic run_op8(input logic [7:0] a_v, input logic [7:0] b_v);
    int cyc;
    @(negedge clk);
    start8 = 1'b1;
    a8     = a_v;
    b8     = b_v;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("w8_busy", 32'(busy8), 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done8 && cyc < 40);
    checkOutput("w8_latency", 32'(cyc), 32'd8);
    checkOutput("w8_diff", 32'(diff8), 32'((int'(a_v) - int'(b_v)) & 255));
    checkOutput("w8_bout", 32'(bout8), 32'(a_v < b_v));
  endtask

  initial begin
    int cyc;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    // 0110 - 1010 wraps to 1100 with a borrow.
    $display("[TB] directed: basic borrow");
    run_op(4'b0110, 4'b1010, 4'b1100, 1'b1, "t1");

    // Start held high: two results exactly five cycles apart.
    $display("[TB] directed: back-to-back");
    applyStimulus(1'b1, 4'b1100, 4'b1011);
    wait_done(cyc);
    checkOutput("t2a_cycles", 32'(cyc), 32'd5);
    checkOutput("t2a_diff", 32'(diff), 32'b0001);
    checkOutput("t2a_bout", 32'(bout), 32'd0);
    a = 4'b0010;
    b = 4'b0001;
    wait_done(cyc);
    checkOutput("t2b_cycles", 32'(cyc), 32'd5);
    checkOutput("t2b_diff", 32'(diff), 32'b0001);
    checkOutput("t2b_bout", 32'(bout), 32'd0);
    start = 1'b0;

    $display("[TB] directed: no borrow, equal, wrap");
    run_op(4'b1111, 4'b0111, 4'b1000, 1'b0, "t3a");
    run_op(4'b0110, 4'b0110, 4'b0000, 1'b0, "t3b");
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b1, "t3c");

    // Operands change and start pulses while busy; captured operands must win.
    $display("[TB] directed: inputs ignored while busy");
    applyStimulus(1'b1, 4'd5, 4'd3);
    applyStimulus(1'b0, 4'd15, 4'd15);
    applyStimulus(1'b1, 4'd0, 4'd9);
    applyStimulus(1'b0, 4'd7, 4'd1);
    wait_done(cyc);
    checkOutput("t4_latency", 32'(cyc), 32'd2);
    checkOutput("t4_diff", 32'(diff), 32'd2);
    checkOutput("t4_bout", 32'(bout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_no_extra_done", 32'(done), 32'd0);
      checkOutput("t4_no_extra_busy", 32'(busy), 32'd0);
    end

    // Asynchronous reset between edges during the second shift cycle.
    $display("[TB] directed: async abort");
    applyStimulus(1'b1, 4'd3, 4'd8);
    applyStimulus(1'b0, 4'd3, 4'd8);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_diff", 32'(diff), 32'd0);
    checkOutput("t5_bout", 32'(bout), 32'd0);
    #1 rst = 1'b0;
    run_op(4'b1001, 4'b0100, 4'b0101, 1'b0, "t5_after");

    $display("[TB] exhaustive 4-bit");
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 4'((x - y) & 15), (x < y), "ex4");
      end
    end

    $display("[TB] 8-bit edge and random pairs");
    run_op8(8'd0, 8'd255);
    run_op8(8'd255, 8'd0);
    run_op8(8'd128, 8'd128);
    run_op8(8'd0, 8'd1);
    for (int i = 0; i < 40; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
